// File: rtl/msg_burst_sequencer_pkg.sv
// msg_seq_pkg: shared types and the message table for msg_burst_sequencer.
// Each table entry is a type bit plus a pulse count; msg_lookup() returns an
// all-zero entry (num = 0, clear pulse only) for indices past the table.
package msg_seq_pkg;

  localparam int TBL_DEPTH = 4;
  localparam int TBL_NUM_W = 4;
  localparam int TBL_IDX_W = $clog2(TBL_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic                 msg_type;
    logic [TBL_NUM_W-1:0] num;
  } msg_t;

  // Entry 0 sits in the low slice: {0,3}, {1,5}, {0,0}, {1,15}
  localparam msg_t [TBL_DEPTH-1:0] MSG_TABLE = {
    msg_t'{msg_type: 1'b1, num: 4'd15},
    msg_t'{msg_type: 1'b0, num: 4'd0},
    msg_t'{msg_type: 1'b1, num: 4'd5},
    msg_t'{msg_type: 1'b0, num: 4'd3}
  };

  function automatic msg_t msg_lookup(input logic [31:0] idx);
    msg_t r;
    r = '0;
    if (idx < 32'(TBL_DEPTH)) r = MSG_TABLE[idx[TBL_IDX_W-1:0]];
    return r;
  endfunction

endpackage

// File: rtl/msg_burst_sequencer_if.sv
// msg_burst_sequencer_if: button input and counter/decoder outputs of the
// sequencer. The sequencer takes the master side; the board/bench the slave.
interface msg_burst_sequencer_if #(
  parameter int NUM_W = 4,
  parameter int IDX_W = 2
);
  logic             next_msg;
  logic             cclr_neg;
  logic             clk_out;
  logic             msg_enable;
  logic             msg_type;
  logic [NUM_W-1:0] num;
  logic [IDX_W-1:0] msg_idx;
  logic             busy;

  modport master (
    input  next_msg,
    output cclr_neg, clk_out, msg_enable, msg_type, num, msg_idx, busy
  );

  modport slave (
    output next_msg,
    input  cclr_neg, clk_out, msg_enable, msg_type, num, msg_idx, busy
  );
endinterface

// File: rtl/msg_burst_sequencer_button_conditioner.sv
// button_conditioner: 2-flop synchronizer, optional debounce, rising-edge
// detect. o_req is a registered single-cycle pulse.
// Optional feature: MSG_SEQ_DEBOUNCE_EN adds a DEB_CYC-cycle stability filter.
// After reset a short warm-up shift register holds off edge detection until
// the synchronizer (and debounce level) reflect the real pin, so a button
// held through reset release never produces a request.
module button_conditioner #(
  parameter int DEB_CYC = 8
) (
  input  logic clk,
  input  logic rst_neg,
  input  logic i_btn,
  output logic o_req
);

  logic [1:0] r_sync;
  logic [3:0] r_warm;
  logic       r_prev;
  logic       r_req;
  logic       w_lvl;

  // two-flop synchronizer on the asynchronous button
  always_ff @(posedge clk) begin
    if (!rst_neg) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_btn};
  end

  // warm-up pipe: bit k set k+1 cycles after reset release
  always_ff @(posedge clk) begin
    if (!rst_neg) r_warm <= '0;
    else          r_warm <= {r_warm[2:0], 1'b1};
  end

`ifdef MSG_SEQ_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             r_deb;
  logic [CNT_W-1:0] r_deb_cnt;

  // level updates only after DEB_CYC consecutive samples at the new value;
  // during warm-up it tracks the synchronizer directly
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (!r_warm[2]) begin
      r_deb     <= r_sync[1];
      r_deb_cnt <= '0;
    end else if (r_sync[1] != r_deb) begin
      if (r_deb_cnt == CNT_W'(DEB_CYC - 1)) begin
        r_deb     <= r_sync[1];
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_lvl = r_deb;
`else
  logic w_unused_deb;
  assign w_unused_deb = ^DEB_CYC;
  assign w_lvl        = r_sync[1];
`endif

  // registered rising-edge detect, gated until the history flop is valid
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      r_prev <= 1'b0;
      r_req  <= 1'b0;
    end else begin
      r_prev <= w_lvl;
      r_req  <= w_lvl & ~r_prev & r_warm[3];
    end
  end

  assign o_req = r_req;

endmodule

// File: rtl/msg_burst_sequencer.sv
// msg_burst_sequencer: each accepted button press plays the next message
// table entry: a CLR_CYC-cycle low pulse on cclr_neg, then num pulses on
// clk_out (DIV high / DIV low) framed by msg_enable, then one DONE cycle
// that advances msg_idx. Presses while busy are dropped.
// Optional feature: MSG_SEQ_DEBOUNCE_EN (debounce in button_conditioner).
module msg_burst_sequencer
  import msg_seq_pkg::*;
#(
  parameter int NUM_MSGS = 4,
  parameter int NUM_W    = 4,
  parameter int DIV      = 4,
  parameter int CLR_CYC  = 2,
  parameter int DEB_CYC  = 8
) (
  input  logic                  clk,
  input  logic                  rst_neg,
  msg_burst_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(NUM_MSGS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_CLEAR = 2'(ST_CLEAR);
  localparam logic [1:0] S_BURST = 2'(ST_BURST);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  logic [1:0]       r_state;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [NUM_W-1:0] r_pulse_cnt;
  logic             r_cclr_neg;
  logic             r_clk_out;
  logic             r_msg_enable;
  logic             r_msg_type;
  logic [NUM_W-1:0] r_num;
  logic [IDX_W-1:0] r_msg_idx;
  logic             r_busy;

  logic             w_req;
  msg_t             w_entry;
  logic [NUM_W-1:0] w_entry_num;
  logic             w_last_pulse;
  logic [IDX_W-1:0] w_idx_next;

  button_conditioner #(.DEB_CYC(DEB_CYC)) u_btn (
    .clk     (clk),
    .rst_neg (rst_neg),
    .i_btn   (bus.next_msg),
    .o_req   (w_req)
  );

  assign w_entry      = msg_lookup(32'(r_msg_idx));
  assign w_entry_num  = NUM_W'(w_entry.num);
  assign w_last_pulse = (r_pulse_cnt == r_num - 1'b1);
  assign w_idx_next   = (r_msg_idx == IDX_W'(NUM_MSGS - 1)) ? '0 : r_msg_idx + 1'b1;

  // sequencer FSM; every output is a flop updated here
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_div_cnt    <= '0;
      r_pulse_cnt  <= '0;
      r_cclr_neg   <= 1'b1;
      r_clk_out    <= 1'b0;
      r_msg_enable <= 1'b0;
      r_msg_type   <= 1'b0;
      r_num        <= '0;
      r_msg_idx    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state    <= S_CLEAR;
            r_cclr_neg <= 1'b0;
            r_busy     <= 1'b1;
            r_clr_cnt  <= '0;
            r_msg_type <= w_entry.msg_type;
            r_num      <= w_entry_num;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == CLR_W'(CLR_CYC - 1)) begin
            // clear ends and the first pulse starts on the same edge
            r_cclr_neg  <= 1'b1;
            r_div_cnt   <= '0;
            r_pulse_cnt <= '0;
            if (r_num == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state      <= S_BURST;
              r_msg_enable <= 1'b1;
              r_clk_out    <= 1'b1;
            end
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_BURST: begin
          if (r_div_cnt == DIV_W'(DIV - 1)) begin
            r_div_cnt <= '0;
            if (r_clk_out) begin
              r_clk_out <= 1'b0;
            end else if (w_last_pulse) begin
              // low phase of the final pulse complete
              r_msg_enable <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_clk_out   <= 1'b1;
              r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_msg_idx <= w_idx_next;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cclr_neg   = r_cclr_neg;
  assign bus.clk_out    = r_clk_out;
  assign bus.msg_enable = r_msg_enable;
  assign bus.msg_type   = r_msg_type;
  assign bus.num        = r_num;
  assign bus.msg_idx    = r_msg_idx;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_msg_burst_sequencer.sv
// tb_msg_burst_sequencer: scoreboard bench. Each press pushes the expected
// message (type, count, index after DONE); a negedge monitor measures every
// busy window and compares it against the popped entry.
`timescale 1ns/1ps
module tb_msg_burst_sequencer;

  localparam int NUM_MSGS = 4;
  localparam int NUM_W    = 4;
  localparam int DIV      = 4;
  localparam int CLR_CYC  = 2;
  localparam int DEB_CYC  = 8;
  localparam int IDX_W    = 2;
`ifdef MSG_SEQ_DEBOUNCE_EN
  localparam int EXP_LAT  = 3 + DEB_CYC;
`else
  localparam int EXP_LAT  = 3;
`endif

  typedef struct {
    int t;
    int n;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_neg = 1'b0;

  msg_burst_sequencer_if #(.NUM_W(NUM_W), .IDX_W(IDX_W)) bus();

  msg_burst_sequencer #(
    .NUM_MSGS (NUM_MSGS),
    .NUM_W    (NUM_W),
    .DIV      (DIV),
    .CLR_CYC  (CLR_CYC),
    .DEB_CYC  (DEB_CYC)
  ) dut (
    .clk     (clk),
    .rst_neg (rst_neg),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   model_idx = 0;
  int   n_bursts = 0;
  bit   abort = 1'b0;
  exp_t q[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  function automatic exp_t model_entry(input int i);
    exp_t e;
    case (i)
      0:       begin e.t = 0; e.n = 3;  end
      1:       begin e.t = 1; e.n = 5;  end
      2:       begin e.t = 0; e.n = 0;  end
      default: begin e.t = 1; e.n = 15; end
    endcase
    e.idx = 0;
    return e;
  endfunction

  // monitor: measure each busy window and score it
  int  m_clr, m_en, m_pulses, m_hi, m_busy;
  bit  prev_busy = 1'b0, prev_clk = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_neg) begin
      if (prev_busy && abort) begin
        if (q.size() > 0) e = q.pop_front();
        abort = 1'b0;
      end
      prev_busy = 1'b0;
      prev_clk  = 1'b0;
      m_hi      = 0;
    end else begin
      if (bus.busy && !prev_busy) begin
        m_clr = 0; m_en = 0; m_pulses = 0; m_hi = 0; m_busy = 0;
        n_bursts++;
        if (q.size() == 0) chk("unexpected_burst", 1, 0);
      end
      if (bus.busy) begin
        m_busy++;
        if (!bus.cclr_neg) m_clr++;
        if (bus.msg_enable) m_en++;
        if (bus.clk_out && !prev_clk) m_pulses++;
        if (bus.clk_out) m_hi++;
        if (!bus.clk_out && prev_clk) begin
          chk("pulse_high_len", m_hi, DIV);
          m_hi = 0;
        end
        if (bus.clk_out && !bus.msg_enable) chk("clk_out_outside_enable", 1, 0);
      end
      if (!bus.busy && prev_busy && q.size() > 0) begin
        e = q.pop_front();
        chk("clr_len",    m_clr,          CLR_CYC);
        chk("enable_len", m_en,           2 * DIV * e.n);
        chk("pulses",     m_pulses,       e.n);
        chk("busy_len",   m_busy,         CLR_CYC + 2 * DIV * e.n + 1);
        chk("msg_type",   bus.msg_type,   e.t);
        chk("num",        bus.num,        e.n);
        chk("msg_idx",    bus.msg_idx,    e.idx);
      end
      prev_busy = bus.busy;
      prev_clk  = bus.clk_out;
    end
  end

  // push the expectation, raise the button, measure request latency
  task automatic press();
    exp_t e;
    int   lat;
    e = model_entry(model_idx);
    model_idx = (model_idx + 1) % NUM_MSGS;
    e.idx = model_idx;
    q.push_back(e);
    @(negedge clk);
    bus.next_msg = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.cclr_neg) break;
    end
    chk("req_latency", lat, EXP_LAT);
  endtask

  task automatic release_btn();
    repeat (16) @(negedge clk);
    bus.next_msg = 1'b0;
    repeat (DEB_CYC + 4) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic play();
    press();
    release_btn();
    wait_idle();
    chk("idx_after", bus.msg_idx, model_idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bus.next_msg = 1'b0;
    // reset with the button toggling
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.next_msg = ~bus.next_msg;
      chk("rst_busy", bus.busy, 0);
      chk("rst_clk_out", bus.clk_out, 0);
    end
    chk("rst_cclr_neg",   bus.cclr_neg,   1);
    chk("rst_msg_enable", bus.msg_enable, 0);
    chk("rst_msg_type",   bus.msg_type,   0);
    chk("rst_num",        bus.num,        0);
    chk("rst_msg_idx",    bus.msg_idx,    0);
    bus.next_msg = 1'b0;
    rst_neg = 1'b1;
    repeat (DEB_CYC + 6) @(negedge clk);
    chk("idx_post_reset", bus.msg_idx, 0);

    // messages 0..3, then wrap to 0
    play();
    play();
    play();
    play();
    play();
    play();
    play();

    // message 3 (15 pulses) with a second press during the burst
    press();
    release_btn();
    bus.next_msg = 1'b1;
    repeat (12) @(negedge clk);
    chk("busy_during_drop", bus.busy, 1);
    bus.next_msg = 1'b0;
    repeat (DEB_CYC + 4) @(negedge clk);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("drop_no_extra", bus.busy, 0);
    chk("idx_after_drop", bus.msg_idx, model_idx);

    // message 0 interrupted by reset after two pulses; button held through reset
    press();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.msg_enable) break;
    end
    chk("enable_seen", bus.msg_enable, 1);
    repeat (4 * DIV - 1) @(negedge clk);
    abort = 1'b1;
    rst_neg = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_clk_out",    bus.clk_out,    0);
    chk("midrst_msg_enable", bus.msg_enable, 0);
    chk("midrst_msg_idx",    bus.msg_idx,    0);
    chk("midrst_busy",       bus.busy,       0);
    chk("midrst_cclr_neg",   bus.cclr_neg,   1);
    repeat (2) @(negedge clk);
    rst_neg = 1'b1;
    model_idx = 0;
    base = n_bursts;
    repeat (30) @(negedge clk);
    chk("held_through_reset", n_bursts - base, 0);
    bus.next_msg = 1'b0;
    repeat (DEB_CYC + 4) @(negedge clk);

    // replay from index 0
    play();

`ifdef MSG_SEQ_DEBOUNCE_EN
    base = n_bursts;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      bus.next_msg = 1'b1;
      repeat (5) @(negedge clk);
      bus.next_msg = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("glitch_no_req", n_bursts - base, 0);
`endif
    play();

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
